// File: rtl/guess_scanner.sv
// Scans the stored word for one guessed letter and keeps the round state.
// Reports new reveals to the fill datapath and tracks misses, win and lose.
module guess_scanner #(
  parameter int unsigned MAX_LEN  = 8,
  parameter int unsigned CHAR_W   = 5,
  parameter int unsigned MAX_MISS = 6,
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int unsigned LW = $clog2(MAX_LEN + 1),
  localparam int unsigned MW = $clog2(MAX_MISS + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               start,
  input  logic [CHAR_W-1:0]  guess,
  input  logic [LW-1:0]      word_len,
  output logic [AW-1:0]      rd_addr,
  input  logic [CHAR_W-1:0]  rd_data,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic               fill_we,
  output logic [AW-1:0]      fill_addr,
  output logic [MAX_LEN-1:0] revealed,
  output logic [MW-1:0]      misses,
  output logic               win,
  output logic               lose
);

  typedef enum logic [1:0] {StIdle, StRead, StCmp, StDone} state_e;

  state_e             state_q, state_d;
  logic [CHAR_W-1:0]  guess_q;
  logic [LW-1:0]      len_q, len_clamped;
  logic [AW-1:0]      idx_q, rd_addr_q;
  logic               hit_q, match_q;
  logic [MAX_LEN-1:0] revealed_q, lenmask;
  logic [MAX_LEN:0]   lenmask_wide;
  logic [MW-1:0]      misses_q;
  logic               accept, eq, last;

  always_comb begin
    len_clamped  = (word_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : word_len;
    // One extra bit so a full-length mask comes out as all ones.
    lenmask_wide = ((MAX_LEN + 1)'(1) << len_q) - (MAX_LEN + 1)'(1);
    lenmask      = lenmask_wide[MAX_LEN-1:0];
    win          = (len_q != '0) && ((revealed_q & lenmask) == lenmask);
    lose         = (misses_q == MW'(MAX_MISS));
    accept       = start && !clear && !win && !lose && (len_clamped != '0);
    eq           = (rd_data == guess_q);
    last         = (LW'(idx_q) == (len_q - LW'(1)));
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    fill_we      = (state_q == StCmp) && eq && !revealed_q[idx_q];
    fill_addr    = idx_q;
    rd_addr      = (state_q == StRead) ? idx_q : rd_addr_q;
    match        = match_q;
    revealed     = revealed_q;
    misses       = misses_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRead;
      StRead:  state_d = StCmp;
      StCmp:   state_d = last ? StDone : StRead;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= StIdle;
      guess_q    <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rd_addr_q  <= '0;
      hit_q      <= 1'b0;
      match_q    <= 1'b0;
      revealed_q <= '0;
      misses_q   <= '0;
    end else if (clear) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      rd_addr_q  <= '0;
      hit_q      <= 1'b0;
      match_q    <= 1'b0;
      revealed_q <= '0;
      misses_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (accept) begin
            guess_q <= guess;
            len_q   <= len_clamped;
            idx_q   <= '0;
            hit_q   <= 1'b0;
          end
        end
        StRead: rd_addr_q <= idx_q;
        StCmp: begin
          if (eq) hit_q <= 1'b1;
          if (fill_we) revealed_q[idx_q] <= 1'b1;
          if (last) begin
            // Result and miss count settle on the edge entering DONE.
            match_q <= hit_q | eq;
            if (!(hit_q || eq) && !lose) misses_q <= misses_q + MW'(1);
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_scanner.sv
// Randomized bench for guess_scanner with a set-based reference model of the game round.
module tb_guess_scanner;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  logic [4:0] guess = '0;
  logic [3:0] word_len = '0;
  logic [2:0] rd_addr;
  logic [4:0] rd_data;
  logic       busy, done, match, fill_we, win, lose;
  logic [2:0] fill_addr;
  logic [7:0] revealed;
  logic [2:0] misses;

  guess_scanner dut (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear),
    .start     (start),
    .guess     (guess),
    .word_len  (word_len),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .match     (match),
    .fill_we   (fill_we),
    .fill_addr (fill_addr),
    .revealed  (revealed),
    .misses    (misses),
    .win       (win),
    .lose      (lose)
  );

  always #5 clk = ~clk;

  // Word register file: synchronous read.
  logic [4:0] mem [8];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int n_checks = 0;
  int n_pass   = 0;

  // Round model: set of revealed positions, miss tally, last result.
  bit [7:0] m_rev   = '0;
  int       m_miss  = 0;
  bit       m_match = 1'b0;
  int       m_len   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic bit m_win();
    if (m_len == 0) return 1'b0;
    for (int i = 0; i < m_len; i++) if (!m_rev[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_rev = '0; m_miss = 0; m_match = 1'b0; m_len = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_match"}, match, m_match);
    check({tag, "_misses"}, misses, m_miss);
    check({tag, "_revealed"}, revealed, m_rev);
    check({tag, "_win"}, win, m_win());
    check({tag, "_lose"}, lose, m_miss == 6);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
    check("clr_busy", busy, 0);
    check_state("clr");
  endtask

  task automatic do_guess(input logic [4:0] g, input int wl);
    int len, busy_cnt, got_cnt, terr, bad, lat;
    bit acc, hit, seen;
    bit [7:0] exp_fill, got_fill;
    len = (wl > 8) ? 8 : wl;
    acc = !m_win() && (m_miss != 6) && (len != 0);
    exp_fill = '0;
    if (acc) begin
      hit = 1'b0;
      for (int i = 0; i < len; i++) begin
        if (mem[i] == g) begin
          hit = 1'b1;
          if (!m_rev[i]) begin exp_fill[i] = 1'b1; m_rev[i] = 1'b1; end
        end
      end
      m_match = hit;
      if (!hit && m_miss < 6) m_miss++;
      m_len = len;
    end
    @(negedge clk); start = 1'b1; guess = g; word_len = 4'(wl);
    @(negedge clk); start = 1'b0; guess = 5'($urandom);
    if (acc) begin
      seen = 1'b0; busy_cnt = 0; got_cnt = 0; got_fill = '0; terr = 0; lat = -1;
      for (int k = 0; k < 40 && !seen; k++) begin
        if (k > 0) @(negedge clk);
        if (busy) busy_cnt++;
        if (fill_we) begin
          got_cnt++;
          got_fill[fill_addr] = 1'b1;
          if (k != 2 * int'(fill_addr) + 1) terr++;
        end
        if (done) begin
          seen = 1'b1;
          lat = k;
          check_state("done");
        end
      end
      check("done_seen", seen, 1);
      check("latency", lat, 2 * len);
      check("busy_cycles", busy_cnt, 2 * len + 1);
      check("fill_count", got_cnt, $countones(exp_fill));
      check("fill_mask", got_fill, exp_fill);
      check("fill_timing", terr, 0);
      @(negedge clk);
      check("idle_after", {busy, done}, 0);
    end else begin
      bad = 0;
      for (int k = 0; k < 4; k++) begin
        if (k > 0) @(negedge clk);
        if (busy || done || fill_we) bad++;
      end
      check("ignored", bad, 0);
      check_state("ign");
    end
  endtask

  initial begin
    int len;
    for (int i = 0; i < 8; i++) mem[i] = 5'($urandom_range(0, 25));

    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fill", {fill_we, fill_addr}, 0);
    check("rst_rd_addr", rd_addr, 0);
    check_state("rst");
    @(negedge clk); resetn = 1'b0;

    // Word [3,0,19]: hit, miss, repeat hit.
    mem[0] = 3; mem[1] = 0; mem[2] = 19;
    do_guess(0, 3);
    check("dir_rev010", revealed, 8'b010);
    do_guess(25, 3);
    do_guess(0, 3);
    check("dir_miss1", misses, 1);

    // Word [4,4,4]: full reveal then locked out.
    do_clear();
    mem[0] = 4; mem[1] = 4; mem[2] = 4;
    do_guess(4, 3);
    check("dir_win", win, 1);
    do_guess(5, 3);

    // Seven misses: sixth sets lose, seventh rejected.
    do_clear();
    mem[0] = 1; mem[1] = 2; mem[2] = 3;
    for (int i = 0; i < 7; i++) do_guess(31, 3);
    check("dir_lose", {lose, misses}, {1'b1, 3'd6});

    // Clear during CMP of position 1.
    do_clear();
    do_guess(30, 3);
    @(negedge clk); start = 1'b1; guess = 2; word_len = 3;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("pre_clr_busy", busy, 1);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
    check("cmp_clr_busy", {busy, done}, 0);
    check_state("cmp_clr");
    do_guess(2, 0);

    // Asynchronous reset while reading position 1.
    mem[0] = 1; mem[1] = 2; mem[2] = 3;
    do_guess(2, 3);
    do_guess(9, 3);
    @(negedge clk); start = 1'b1; guess = 3; word_len = 3;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    check("pre_rst_rd_addr", rd_addr, 1);
    #1 resetn = 1'b1;
    #1;
    model_clear();
    check("arst_busy", busy, 0);
    check("arst_rd_addr", rd_addr, 0);
    check("arst_fill", {fill_we, fill_addr}, 0);
    check_state("arst");
    @(negedge clk); resetn = 1'b0;

    // Over-length word is clamped to 8 positions.
    for (int i = 0; i < 8; i++) mem[i] = 5'($urandom_range(0, 3));
    do_guess(5'($urandom_range(0, 3)), 12);

    // Random rounds.
    for (int r = 0; r < 30; r++) begin
      do_clear();
      for (int i = 0; i < 8; i++) mem[i] = 5'($urandom_range(0, 5));
      len = $urandom_range(0, 10);
      for (int j = 0; j < 9; j++) begin
        if ($urandom_range(0, 7) == 0) len = $urandom_range(0, 10);
        do_guess(5'($urandom_range(0, 7)), len);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
